rob_recovery_ctrl: RTL and testbench

Sequences pipeline recovery around the reorder buffer on a branch mispredict or a trap. Pulses the ROB flush, drains in-flight functional-unit ops, and walks the RRAT to rebuild the speculative RAT one register per cycle. Then redirects the front-end PC. Sits between the branch unit/exception logic, the reorder buffer, the rename tables and fetch.

---
 rtl/rob_recovery_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_rob_recovery_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_recovery_ctrl.sv
// rob_recovery_ctrl: sequences pipeline recovery after a branch mispredict or
// a trap. The sequence is: pulse the ROB flush, drain the in-flight FU ops,
// rebuild the speculative RAT from the RRAT one register per cycle, then
// redirect fetch.
// Optional build macro ROB_RECOVERY_TIMEOUT_EN adds a drain watchdog. When it
// is undefined, DRAIN waits indefinitely and drain_timeout_out is tied 0.
//
// Signalling: mispredict_valid_in and trap_valid_in are single-cycle pulses
// with no back-pressure. A trap is never dropped: it either starts a sequence
// or retargets the one in progress. A mispredict is dropped while busy.
// issue_valid_in and complete_valid_in are per-FU event strobes.
// rob_flush_out and valid_pc_out are one-cycle pulses. pc_out holds target_q
// at all times and is meaningful only while valid_pc_out is high.
module rob_recovery_ctrl #(
   parameter int ADDR_BITS     = 64,
   parameter int NUM_ARCH_REGS = 32,
   parameter int NUM_PHYS_REGS = 128,
   parameter int NUM_FU        = 4,
   parameter int MAX_INFLIGHT  = 15,
   parameter int DRAIN_TIMEOUT = 255
) (
   input  logic                                 clk_in,
   input  logic                                 rst_in,
   input  logic                                 mispredict_valid_in,
   input  logic [ADDR_BITS-1:0]                 mispredict_pc_in,
   input  logic                                 trap_valid_in,
   input  logic [ADDR_BITS-1:0]                 trap_pc_in,
   input  logic [NUM_FU-1:0]                    issue_valid_in,
   input  logic [NUM_FU-1:0]                    complete_valid_in,
   output logic                                 rob_flush_out,
   output logic                                 stall_out,
   output logic [$clog2(NUM_ARCH_REGS)-1:0]     rrat_rd_idx_out,
   input  logic [$clog2(NUM_PHYS_REGS)-1:0]     rrat_rd_preg_in,
   output logic                                 rat_wr_valid_out,
   output logic [$clog2(NUM_ARCH_REGS)-1:0]     rat_wr_idx_out,
   output logic [$clog2(NUM_PHYS_REGS)-1:0]     rat_wr_preg_out,
   output logic                                 valid_pc_out,
   output logic [ADDR_BITS-1:0]                 pc_out,
   output logic                                 drain_timeout_out,
   output logic [1:0]                           state_out
);
   localparam int IDX_W  = $clog2(NUM_ARCH_REGS);
   localparam int PREG_W = $clog2(NUM_PHYS_REGS);
   localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1);
   localparam int POP_W  = $clog2(NUM_FU + 1);
   localparam int SUM_W  = ((CNT_W > POP_W) ? CNT_W : POP_W) + 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ARCH_REGS - 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_INFLIGHT);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DRAIN    = 2'd1,
      RESTORE  = 2'd2,
      REDIRECT = 2'd3
   } state_t;

   state_t                 state_q;
   logic [ADDR_BITS-1:0]   target_q;
   logic [CNT_W-1:0]       inflight_cnt;
   logic [IDX_W-1:0]       idx_q;
   logic                   first_q;
   logic [POP_W-1:0]       issue_pop;
   logic [POP_W-1:0]       comp_pop;
   logic [SUM_W-1:0]       cnt_up;
   logic [CNT_W-1:0]       cnt_next;

`ifdef ROB_RECOVERY_TIMEOUT_EN
   localparam int WD_W = ($clog2(DRAIN_TIMEOUT + 1) > 8) ? $clog2(DRAIN_TIMEOUT + 1) : 8;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(DRAIN_TIMEOUT - 1);
   logic [WD_W-1:0] wd_cnt;
   logic            drain_timeout_q;
   assign drain_timeout_out = drain_timeout_q;
`else
   assign drain_timeout_out = 1'b0;
`endif

   // In-flight op count: apply this cycle's net issue/complete, then saturate at both ends.
   always_comb begin
      issue_pop = '0;
      comp_pop  = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         issue_pop = issue_pop + POP_W'(issue_valid_in[i]);
         comp_pop  = comp_pop + POP_W'(complete_valid_in[i]);
      end
      cnt_up = SUM_W'(inflight_cnt) + SUM_W'(issue_pop);
      if (cnt_up < SUM_W'(comp_pop)) begin
         cnt_next = '0;
      end else if ((cnt_up - SUM_W'(comp_pop)) > SUM_W'(MAX_INFLIGHT)) begin
         cnt_next = MAX_CNT;
      end else begin
         cnt_next = CNT_W'(cnt_up - SUM_W'(comp_pop));
      end
   end

   // Recovery sequencer. A trap arriving mid-sequence retargets the redirect
   // without restarting, because the RRAT contents have not changed.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         target_q     <= '0;
         inflight_cnt <= '0;
         idx_q        <= '0;
         first_q      <= 1'b0;
`ifdef ROB_RECOVERY_TIMEOUT_EN
         wd_cnt          <= '0;
         drain_timeout_q <= 1'b0;
`endif
      end else begin
         inflight_cnt <= cnt_next;
         first_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (trap_valid_in) begin
                  target_q <= trap_pc_in;
                  state_q  <= DRAIN;
                  first_q  <= 1'b1;
`ifdef ROB_RECOVERY_TIMEOUT_EN
                  wd_cnt   <= '0;
`endif
               end else if (mispredict_valid_in) begin
                  target_q <= mispredict_pc_in;
                  state_q  <= DRAIN;
                  first_q  <= 1'b1;
`ifdef ROB_RECOVERY_TIMEOUT_EN
                  wd_cnt   <= '0;
`endif
               end
            end
            DRAIN: begin
               if (trap_valid_in) target_q <= trap_pc_in;
               if (inflight_cnt == '0) begin
                  state_q <= RESTORE;
               end
`ifdef ROB_RECOVERY_TIMEOUT_EN
               else if (wd_cnt == WD_LAST) begin
                  state_q         <= RESTORE;
                  inflight_cnt    <= '0;
                  drain_timeout_q <= 1'b1;
               end
               wd_cnt <= wd_cnt + WD_W'(1);
`endif
            end
            RESTORE: begin
               if (trap_valid_in) target_q <= trap_pc_in;
               if (idx_q == LAST_IDX) begin
                  idx_q   <= '0;
                  state_q <= REDIRECT;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            REDIRECT: begin
               if (trap_valid_in) begin
                  target_q <= trap_pc_in;
                  state_q  <= DRAIN;
                  first_q  <= 1'b1;
`ifdef ROB_RECOVERY_TIMEOUT_EN
                  wd_cnt   <= '0;
`endif
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Output decode from the registered state; stall also covers the request cycle.
   always_comb begin
      stall_out        = (state_q != IDLE) | mispredict_valid_in | trap_valid_in;
      rob_flush_out    = (state_q == DRAIN) & first_q;
      rat_wr_valid_out = (state_q == RESTORE);
      rrat_rd_idx_out  = (state_q == RESTORE) ? idx_q : '0;
      rat_wr_idx_out   = (state_q == RESTORE) ? idx_q : '0;
      rat_wr_preg_out  = (state_q == RESTORE) ? rrat_rd_preg_in : PREG_W'(0);
      valid_pc_out     = (state_q == REDIRECT);
      pc_out           = target_q;
      state_out        = state_q;
   end
endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Bench for rob_recovery_ctrl: reset checks, a vector table, hand-written
// corner sequences, and a randomized run checked against a reference model.
module tb_rob_recovery_ctrl;
   localparam int AB = 64, NAR = 32, NPR = 128, NFU = 4, MAXI = 15, DTO = 16;
   localparam int IW = $clog2(NAR), PW = $clog2(NPR);

   logic            clk_in = 1'b0;
   logic            rst_in;
   logic            mispredict_valid_in, trap_valid_in;
   logic [AB-1:0]   mispredict_pc_in, trap_pc_in;
   logic [NFU-1:0]  issue_valid_in, complete_valid_in;
   logic            rob_flush_out, stall_out, rat_wr_valid_out, valid_pc_out, drain_timeout_out;
   logic [IW-1:0]   rrat_rd_idx_out, rat_wr_idx_out;
   logic [PW-1:0]   rrat_rd_preg_in, rat_wr_preg_out;
   logic [AB-1:0]   pc_out;
   logic [1:0]      state_out;
   logic [PW-1:0]   rrat_mem [NAR];

   rob_recovery_ctrl #(.ADDR_BITS(AB), .NUM_ARCH_REGS(NAR), .NUM_PHYS_REGS(NPR),
                       .NUM_FU(NFU), .MAX_INFLIGHT(MAXI), .DRAIN_TIMEOUT(DTO)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .mispredict_valid_in(mispredict_valid_in), .mispredict_pc_in(mispredict_pc_in),
      .trap_valid_in(trap_valid_in), .trap_pc_in(trap_pc_in),
      .issue_valid_in(issue_valid_in), .complete_valid_in(complete_valid_in),
      .rob_flush_out(rob_flush_out), .stall_out(stall_out),
      .rrat_rd_idx_out(rrat_rd_idx_out), .rrat_rd_preg_in(rrat_rd_preg_in),
      .rat_wr_valid_out(rat_wr_valid_out), .rat_wr_idx_out(rat_wr_idx_out),
      .rat_wr_preg_out(rat_wr_preg_out), .valid_pc_out(valid_pc_out), .pc_out(pc_out),
      .drain_timeout_out(drain_timeout_out), .state_out(state_out));

   // Clock and the RRAT behaving as a combinational-read memory.
   always #5 clk_in = ~clk_in;
   assign rrat_rd_preg_in = rrat_mem[rrat_rd_idx_out];

   int total = 0, bad = 0, cyc = 0, obs_cyc = 0, flush_seen = 0, vpc_seen = 0;
   logic            obs_stall, obs_flush, obs_rwv, obs_vpc, obs_to;
   logic [IW-1:0]   obs_widx, obs_ridx;
   logic [PW-1:0]   obs_preg;
   logic [AB-1:0]   obs_pc;
   logic [1:0]      obs_state;

   // Reference model: drain age, remaining restore writes, pending redirect.
   int            m_cnt, m_age, m_left;
   bit            m_redir, m_to;
   logic [AB-1:0] m_target;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, obs_cyc, act, exp);
      end
   endtask

   function automatic int ones(input logic [NFU-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < NFU; i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_age = -1; m_left = 0; m_redir = 0; m_to = 0; m_target = '0;
   endtask

   task automatic model_compare();
      bit busy;
      int widx;
      busy = (m_age >= 0) || (m_left > 0) || m_redir;
      widx = (m_left > 0) ? NAR - m_left : 0;
      chk("m_stall", obs_stall, busy || mispredict_valid_in || trap_valid_in);
      chk("m_flush", obs_flush, m_age == 0);
      chk("m_rat_wr_valid", obs_rwv, m_left > 0);
      chk("m_rat_wr_idx", obs_widx, widx);
      chk("m_rrat_rd_idx", obs_ridx, widx);
      chk("m_rat_wr_preg", obs_preg, (m_left > 0) ? 64'(rrat_mem[widx]) : 64'd0);
      chk("m_valid_pc", obs_vpc, m_redir);
      chk("m_pc", obs_pc, m_target);
      chk("m_timeout", obs_to, m_to);
   endtask

   task automatic model_step();
      int nc;
      if (rst_in) begin
         model_reset();
         return;
      end
      nc = m_cnt + ones(issue_valid_in) - ones(complete_valid_in);
      if (nc < 0) nc = 0;
      if (nc > MAXI) nc = MAXI;
      if (m_age >= 0) begin
         if (trap_valid_in) m_target = trap_pc_in;
         if (m_cnt == 0) begin
            m_age = -1; m_left = NAR;
         end
`ifdef ROB_RECOVERY_TIMEOUT_EN
         else if (m_age == DTO - 1) begin
            m_age = -1; m_left = NAR; nc = 0; m_to = 1;
         end
`endif
         else m_age++;
      end else if (m_left > 0) begin
         if (trap_valid_in) m_target = trap_pc_in;
         m_left--;
         if (m_left == 0) m_redir = 1;
      end else if (m_redir) begin
         m_redir = 0;
         if (trap_valid_in) begin m_target = trap_pc_in; m_age = 0; end
      end else if (trap_valid_in) begin
         m_target = trap_pc_in; m_age = 0;
      end else if (mispredict_valid_in) begin
         m_target = mispredict_pc_in; m_age = 0;
      end
      m_cnt = nc;
   endtask

   // One cycle: snapshot outputs mid-cycle, check against model, advance model.
   task automatic tick();
      @(negedge clk_in);
      obs_cyc = cyc;
      obs_stall = stall_out; obs_flush = rob_flush_out; obs_rwv = rat_wr_valid_out;
      obs_widx = rat_wr_idx_out; obs_ridx = rrat_rd_idx_out; obs_preg = rat_wr_preg_out;
      obs_vpc = valid_pc_out; obs_pc = pc_out; obs_to = drain_timeout_out; obs_state = state_out;
      if (obs_flush) flush_seen++;
      if (obs_vpc) vpc_seen++;
      model_compare();
      model_step();
      @(posedge clk_in);
      #1;
      cyc++;
   endtask

   task automatic clear_inputs();
      mispredict_valid_in = 0; trap_valid_in = 0; issue_valid_in = '0; complete_valid_in = '0;
   endtask

   task automatic request(input bit is_trap, input logic [AB-1:0] pc, output int t0);
      t0 = cyc;
      if (is_trap) begin trap_valid_in = 1; trap_pc_in = pc; end
      else begin mispredict_valid_in = 1; mispredict_pc_in = pc; end
      tick();
      clear_inputs();
   endtask

   task automatic wait_redirect(input int limit);
      int n;
      n = 0;
      while (!obs_vpc && n < limit) begin tick(); n++; end
      chk("redirect_seen", obs_vpc, 1);
   endtask

   typedef struct {
      logic          mp;
      logic          trap;
      logic [AB-1:0] mp_pc;
      logic [AB-1:0] trap_pc;
      logic          exp_stall;
      logic          exp_flush;
      logic [AB-1:0] exp_pc;
   } vec_t;
   vec_t vecs[5];

   initial begin
      int t0;
      vecs[0] = '{0, 0, 64'h0,    64'h0,    0, 0, 64'h0};
      vecs[1] = '{1, 0, 64'h1000, 64'h0,    1, 1, 64'h1000};
      vecs[2] = '{0, 1, 64'h0,    64'h4000, 1, 1, 64'h4000};
      vecs[3] = '{1, 1, 64'h2000, 64'h8000, 1, 1, 64'h8000};
      vecs[4] = '{1, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF0};
      for (int i = 0; i < NAR; i++) rrat_mem[i] = PW'($urandom_range(0, NPR - 1));
      clear_inputs();
      mispredict_pc_in = '0; trap_pc_in = '0;
      model_reset();
      rst_in = 1;
      tick(); tick();
      rst_in = 0;
      tick();
      chk("rst_stall", obs_stall, 0);
      chk("rst_flush", obs_flush, 0);
      chk("rst_rat_wr_valid", obs_rwv, 0);
      chk("rst_valid_pc", obs_vpc, 0);
      chk("rst_pc", obs_pc, 0);

      // Vector table: one request from idle, then the full sequence timing.
      for (int i = 0; i < 5; i++) begin
         t0 = cyc;
         mispredict_valid_in = vecs[i].mp; mispredict_pc_in = vecs[i].mp_pc;
         trap_valid_in = vecs[i].trap; trap_pc_in = vecs[i].trap_pc;
         tick();
         clear_inputs();
         chk("vec_stall", obs_stall, vecs[i].exp_stall);
         tick();
         chk("vec_flush", obs_flush, vecs[i].exp_flush);
         if (vecs[i].exp_flush) begin
            tick();
            chk("vec_first_wr_valid", obs_rwv, 1);
            chk("vec_first_wr_idx", obs_widx, 0);
            chk("vec_first_wr_preg", obs_preg, rrat_mem[0]);
            wait_redirect(100);
            chk("vec_latency", obs_cyc - t0, NAR + 2);
            chk("vec_pc", obs_pc, vecs[i].exp_pc);
            tick();
            chk("vec_idle_stall", obs_stall, 0);
         end
      end

      // Three ops in flight (LSU, ALU, FPU), completions spread out.
      issue_valid_in = 4'b1101; tick(); clear_inputs();
      request(0, 64'h3000, t0);
      tick();
      chk("ops_flush", obs_flush, 1);
      complete_valid_in = 4'b0100; tick(); clear_inputs(); tick();
      complete_valid_in = 4'b1000; tick(); clear_inputs(); tick();
      complete_valid_in = 4'b0001; tick(); clear_inputs();
      tick();
      chk("ops_still_drain", obs_rwv, 0);
      tick();
      chk("ops_first_wr_cycle", obs_rwv, 1);
      chk("ops_first_wr_at", obs_cyc - t0, 8);
      wait_redirect(100);
      chk("ops_pc", obs_pc, 64'h3000);
      tick();

      // Saturation: 20 issues clamp to 15, so 15 completions fully drain.
      for (int i = 0; i < 5; i++) begin issue_valid_in = 4'hF; tick(); end
      clear_inputs();
      request(0, 64'h3300, t0);
      for (int i = 0; i < 3; i++) begin complete_valid_in = 4'hF; tick(); end
      complete_valid_in = 4'b0111; tick(); clear_inputs();
      tick();
      chk("sat_drain", obs_rwv, 0);
      tick();
      chk("sat_restore", obs_rwv, 1);
      wait_redirect(100);
      tick();

      // Mispredict ignored and trap retargets while restoring.
      flush_seen = 0;
      request(0, 64'h2000, t0);
      for (int i = 0; i < 4; i++) tick();
      mispredict_valid_in = 1; mispredict_pc_in = 64'h5000; tick(); clear_inputs();
      trap_valid_in = 1; trap_pc_in = 64'h9000; tick(); clear_inputs();
      wait_redirect(100);
      chk("rtrap_pc", obs_pc, 64'h9000);
      chk("rtrap_latency", obs_cyc - t0, NAR + 2);
      chk("rtrap_flushes", flush_seen, 1);
      tick();

      // Trap during the redirect cycle: old redirect emitted, then a new sequence.
      request(0, 64'h1111, t0);
      while (cyc < t0 + NAR + 2) tick();
      trap_valid_in = 1; trap_pc_in = 64'hA000; tick(); clear_inputs();
      chk("xtrap_old_valid", obs_vpc, 1);
      chk("xtrap_old_pc", obs_pc, 64'h1111);
      tick();
      chk("xtrap_second_flush", obs_flush, 1);
      chk("xtrap_stall", obs_stall, 1);
      wait_redirect(100);
      chk("xtrap_new_pc", obs_pc, 64'hA000);
      chk("xtrap_latency", obs_cyc - t0, 2 * (NAR + 2));
      tick();

      // Reset in the middle of the restore walk.
      request(0, 64'h4444, t0);
      while (cyc < t0 + 12) tick();
      rst_in = 1; tick(); rst_in = 0;
      chk("mrst_idx_before", obs_widx, 10);
      tick();
      chk("mrst_stall", obs_stall, 0);
      chk("mrst_rat_wr_valid", obs_rwv, 0);
      chk("mrst_rat_wr_idx", obs_widx, 0);
      chk("mrst_preg", obs_preg, 0);
      chk("mrst_pc", obs_pc, 0);
      vpc_seen = 0;
      for (int i = 0; i < 40; i++) tick();
      chk("mrst_no_redirect", vpc_seen, 0);

      // One op that never completes.
      issue_valid_in = 4'b0010; tick(); clear_inputs();
      request(0, 64'h7777, t0);
`ifdef ROB_RECOVERY_TIMEOUT_EN
      while (!obs_rwv && cyc < t0 + 100) tick();
      chk("wd_restore_at", obs_cyc - t0, DTO + 1);
      chk("wd_flag", obs_to, 1);
      wait_redirect(100);
      for (int i = 0; i < 5; i++) tick();
      chk("wd_flag_sticky", obs_to, 1);
      rst_in = 1; tick(); rst_in = 0; tick();
      chk("wd_flag_reset", obs_to, 0);
`else
      for (int i = 0; i < 300; i++) tick();
      chk("hold_state", obs_state, 2'd1);
      chk("hold_timeout", obs_to, 0);
      chk("hold_stall", obs_stall, 1);
      complete_valid_in = 4'b0010; tick(); clear_inputs();
      wait_redirect(100);
      chk("hold_pc", obs_pc, 64'h7777);
      tick();
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         mispredict_valid_in = ($urandom_range(0, 39) == 0);
         trap_valid_in = ($urandom_range(0, 59) == 0);
         mispredict_pc_in = {$urandom, $urandom};
         trap_pc_in = {$urandom, $urandom};
         for (int b = 0; b < NFU; b++) begin
            issue_valid_in[b] = ($urandom_range(0, 7) == 0);
            complete_valid_in[b] = ($urandom_range(0, 5) == 0);
         end
         rst_in = ($urandom_range(0, 799) == 0);
         if (n % 500 == 0) rrat_mem[$urandom_range(0, NAR - 1)] = PW'($urandom_range(0, NPR - 1));
         tick();
      end
      clear_inputs();
      rst_in = 0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
